// File: rtl/instr_encoder_writer_if.sv
// Request and memory-bus bundle for instr_encoder_writer.
// slave is the encoder side; master is the loader/memory side.
interface instr_encoder_writer_if #(
  parameter int MAX_WORDS = 256
);
  localparam int CW = $clog2(MAX_WORDS) + 1;

  logic          start;
  logic [31:0]   start_address;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_fmt;
  logic [6:0]    req_opcode;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [2:0]    req_funct3;
  logic [6:0]    req_funct7;
  logic [31:0]   req_imm;
  logic          mem_valid;
  logic [31:0]   mem_address;
  logic [3:0]    mem_wstrobe;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [CW-1:0] word_count;
  logic          wrapped;
  logic          fmt_error;
  logic          imm_error;

  modport slave (
    input  start, start_address, req_valid, req_fmt, req_opcode, req_rd,
           req_rs1, req_rs2, req_funct3, req_funct7, req_imm, mem_ready,
    output req_ready, mem_valid, mem_address, mem_wstrobe, mem_wdata,
           word_count, wrapped, fmt_error, imm_error
  );

  modport master (
    output start, start_address, req_valid, req_fmt, req_opcode, req_rd,
           req_rs1, req_rs2, req_funct3, req_funct7, req_imm, mem_ready,
    input  req_ready, mem_valid, mem_address, mem_wstrobe, mem_wdata,
           word_count, wrapped, fmt_error, imm_error
  );
endinterface

// File: rtl/instr_encoder_writer.sv
// Streaming RV32I encoder that writes encoded words to consecutive addresses.
// Define INSTR_ENCODER_IMM_CHECK_EN to range-check immediates per format.
module instr_encoder_writer #(
  parameter int MAX_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_encoder_writer_if.slave bus
);
  localparam int IW = $clog2(MAX_WORDS);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, READY, WRITE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_base;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [IW-1:0] r_index;
  logic [CW-1:0] r_count;
  logic          r_wrapped;
  logic          r_fmt_err;
  logic          r_imm_err;

  logic          w_arm;
  logic          w_accept;
  logic          w_done;
  logic          w_fmt_bad;
  logic          w_imm_bad;
  logic          w_legal;
  logic [31:0]   w_word;
  logic [31:0]   w_start_addr;

  // start wins over a concurrent request in READY; that request is dropped
  assign w_arm        = bus.start && (r_state != WRITE);
  assign w_accept     = (r_state == READY) && bus.req_valid && !bus.start;
  assign w_done       = (r_state == WRITE) && bus.mem_ready;
  assign w_fmt_bad    = bus.req_fmt > 3'd5;
  assign w_legal      = !w_fmt_bad && !w_imm_bad;
  assign w_start_addr = bus.start_address & ~32'h3;

  always_comb begin
    w_word = 32'h0;
    case (bus.req_fmt)
      3'd0: w_word = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                      bus.req_rd, bus.req_opcode};
      3'd1: w_word = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3,
                      bus.req_rd, bus.req_opcode};
      3'd2: w_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                      bus.req_imm[4:0], bus.req_opcode};
      3'd3: w_word = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                      bus.req_funct3, bus.req_imm[4:1], bus.req_imm[11], bus.req_opcode};
      3'd4: w_word = {bus.req_imm[31:12], bus.req_rd, bus.req_opcode};
      3'd5: w_word = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                      bus.req_imm[19:12], bus.req_rd, bus.req_opcode};
      default: w_word = 32'h0;
    endcase
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  // A value fits in N signed bits when every bit from N-1 up equals the sign bit
  always_comb begin
    w_imm_bad = 1'b0;
    case (bus.req_fmt)
      3'd1, 3'd2: w_imm_bad = !(&bus.req_imm[31:11] || ~|bus.req_imm[31:11]);
      3'd3: w_imm_bad = !(&bus.req_imm[31:12] || ~|bus.req_imm[31:12]) || bus.req_imm[0];
      3'd4: w_imm_bad = |bus.req_imm[11:0];
      3'd5: w_imm_bad = !(&bus.req_imm[31:20] || ~|bus.req_imm[31:20]) || bus.req_imm[0];
      default: w_imm_bad = 1'b0;
    endcase
  end
`else
  assign w_imm_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = READY;
      READY:   if (w_accept && w_legal) w_state_next = WRITE;
      WRITE:   if (bus.mem_ready) w_state_next = READY;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base    <= 32'h0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_index   <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_fmt_err <= 1'b0;
      r_imm_err <= 1'b0;
    end else if (w_arm) begin
      r_base    <= w_start_addr;
      r_addr    <= w_start_addr;
      r_index   <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_fmt_err <= 1'b0;
      r_imm_err <= 1'b0;
    end else if (w_accept) begin
      if (w_legal)   r_wdata   <= w_word;
      if (w_fmt_bad) r_fmt_err <= 1'b1;
      else if (w_imm_bad) r_imm_err <= 1'b1;
    end else if (w_done) begin
      if (r_index == IW'(MAX_WORDS - 1)) begin
        r_index   <= '0;
        r_addr    <= r_base;
        r_wrapped <= 1'b1;
      end else begin
        r_index <= r_index + 1'b1;
        r_addr  <= r_addr + 32'd4;
      end
      if (r_count != CW'(MAX_WORDS)) r_count <= r_count + 1'b1;
    end
  end

  assign bus.req_ready   = (r_state == READY);
  assign bus.mem_valid   = (r_state == WRITE);
  assign bus.mem_address = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.mem_wstrobe = (r_state == WRITE) ? 4'hF : 4'h0;
  assign bus.word_count  = r_count;
  assign bus.wrapped     = r_wrapped;
  assign bus.fmt_error   = r_fmt_err;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
  assign bus.imm_error   = r_imm_err;
`else
  assign bus.imm_error   = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed bench for instr_encoder_writer with MAX_WORDS=4 so wrap-around is reachable.
module tb_instr_encoder_writer;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instr_encoder_writer_if #(.MAX_WORDS(4)) bus ();

  instr_encoder_writer #(.MAX_WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic start_session(input logic [31:0] addr);
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_address = addr;
    @(negedge clk);
    bus.start = 1'b0;
    check("armed_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("armed_word_count", 32'(bus.word_count), 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int n = 0;
    bus.req_fmt = fmt;   bus.req_opcode = op;  bus.req_rd = rd;
    bus.req_rs1 = rs1;   bus.req_rs2 = rs2;    bus.req_funct3 = f3;
    bus.req_funct7 = f7; bus.req_imm = imm;    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("req_ready_timeout", 32'h0, 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Waits for the write (mem_ready assumed 1) and lets it complete
  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    while (!bus.mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check({tag, "_timeout"}, 32'h0, 32'h1);
    check({tag, "_addr"}, bus.mem_address, addr);
    check({tag, "_data"}, bus.mem_wdata, data);
    check({tag, "_strobe"}, {28'h0, bus.mem_wstrobe}, 32'hF);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h0);
    check({tag, "_mem_valid"}, {31'h0, bus.mem_valid}, 32'h0);
    check({tag, "_mem_address"}, bus.mem_address, 32'h0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    check({tag, "_mem_wstrobe"}, {28'h0, bus.mem_wstrobe}, 32'h0);
    check({tag, "_word_count"}, 32'(bus.word_count), 32'h0);
    check({tag, "_flags"}, {29'h0, bus.wrapped, bus.fmt_error, bus.imm_error}, 32'h0);
  endtask

  logic [31:0] held_addr;
  logic [31:0] held_data;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;     bus.start_address = 32'h0;
    bus.req_valid = 1'b0; bus.req_fmt = 3'd0;    bus.req_opcode = 7'h0;
    bus.req_rd = 5'd0;    bus.req_rs1 = 5'd0;    bus.req_rs2 = 5'd0;
    bus.req_funct3 = 3'd0; bus.req_funct7 = 7'h0; bus.req_imm = 32'h0;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // I and R
    start_session(32'h0000_0103);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
    expect_write("addi", 32'h100, 32'h0050_0093);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h0, 32'd0);
    expect_write("add", 32'h104, 32'h0020_81B3);
    check("g1_word_count", 32'(bus.word_count), 32'd2);

    // S and B
    start_session(32'h200);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, 32'd8);
    expect_write("sw", 32'h200, 32'h0020_A423);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, -32'sd4);
    expect_write("beq", 32'h204, 32'hFE00_0EE3);

    // J and U
    start_session(32'h300);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
    expect_write("jal", 32'h300, 32'h0010_00EF);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000);
    expect_write("lui", 32'h304, 32'h1234_52B7);

    // Back-pressure: outputs must hold while mem_ready is low
    start_session(32'h400);
    bus.mem_ready = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1);
    check("stall_valid", {31'h0, bus.mem_valid}, 32'h1);
    held_addr = bus.mem_address;
    held_data = bus.mem_wdata;
    check("stall_data", held_data, 32'h0010_0113);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_valid", {31'h0, bus.mem_valid}, 32'h1);
      check("stall_hold_addr", bus.mem_address, 32'h400);
      check("stall_hold_data", bus.mem_wdata, 32'h0010_0113);
      check("stall_req_ready", {31'h0, bus.req_ready}, 32'h0);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("post_stall_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("post_stall_valid", {31'h0, bus.mem_valid}, 32'h0);

    // Wrap-around after MAX_WORDS=4 writes
    start_session(32'h40);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) check("prewrap_wrapped", {31'h0, bus.wrapped}, 32'h0);
      send(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'h0, 32'(i));
      expect_write("wrap_seq", 32'h40 + 32'(4 * (i % 4)),
                   (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
      if (i == 3) check("wrap4_word_count", 32'(bus.word_count), 32'd4);
    end
    check("wrap_wrapped", {31'h0, bus.wrapped}, 32'h1);
    check("wrap_word_count_sat", 32'(bus.word_count), 32'd4);

    // Illegal format: accepted, nothing written, flag set
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0);
    check("badfmt_no_write", {31'h0, bus.mem_valid}, 32'h0);
    @(negedge clk);
    check("badfmt_no_write2", {31'h0, bus.mem_valid}, 32'h0);
    check("badfmt_flag", {31'h0, bus.fmt_error}, 32'h1);
    check("badfmt_req_ready", {31'h0, bus.req_ready}, 32'h1);

    // Out-of-range I immediate
    start_session(32'h500);
    check("rearm_fmt_flag", {31'h0, bus.fmt_error}, 32'h0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    check("badimm_no_write", {31'h0, bus.mem_valid}, 32'h0);
    @(negedge clk);
    check("badimm_no_write2", {31'h0, bus.mem_valid}, 32'h0);
    check("badimm_flag", {31'h0, bus.imm_error}, 32'h1);
`else
    expect_write("imm_trunc", 32'h500, 32'h8000_0093);
    check("imm_flag_tied", {31'h0, bus.imm_error}, 32'h0);
`endif

    // Reset in the middle of a write
    start_session(32'h600);
    bus.mem_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
    check("prereset_valid", {31'h0, bus.mem_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midwrite_reset");
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'h0, bus.req_ready}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
